// File: rtl/ok_trigger_out_framer.sv
// Frames local trigger edges and wire-out requests into byte-swapped 16-bit words
// for the OK word bus: trigger frames are HEADER + {ep_addr, triggers}.
module ok_trigger_out_framer #(
    parameter logic [15:0] HEADER       = 16'hC7E5,
    parameter logic [15:0] UPDATAHEADER = 16'hB79E,
    parameter int unsigned GAP_CYCLES   = 1
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [7:0]  trig_in,
    input  logic [7:0]  ep_addr,
    input  logic        wire_req,
    input  logic [15:0] wire_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [15:0] tx_data,
    output logic [2:0]  STATE,
    output logic        trig_sent,
    output logic        wire_done,
    output logic        wire_busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        T_HDR  = 3'd1,
        T_PAY  = 3'd2,
        W_HDR  = 3'd3,
        W_ADDR = 3'd4,
        W_DATA = 3'd5,
        GAP    = 3'd6
    } state_t;

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_t      state;
    logic [7:0]  trig_prev;
    logic [7:0]  pend;
    logic [7:0]  tsnap;
    logic [7:0]  ep_lat;
    logic [15:0] wire_buf;
    logic [3:0]  gap_cnt;

    logic [7:0]  trig_edge;
    logic [7:0]  pend_clr;
    logic        accept;
    logic        wire_take;

    function automatic logic [15:0] swap_bytes(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

    // Snapshot clears only the bits it took; a fresh edge in that same cycle re-sets them.
    always_comb begin
        trig_edge = trig_in & ~trig_prev;
        pend_clr  = (state == IDLE) ? pend : 8'h00;
        accept    = tx_valid & tx_ready;
        wire_take = wire_req & ~wire_busy & ~wire_done;
    end

    assign STATE = state;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= IDLE;
            trig_prev <= 8'h00;
            pend      <= 8'h00;
            tsnap     <= 8'h00;
            ep_lat    <= 8'h00;
            wire_buf  <= 16'h0000;
            gap_cnt   <= 4'd0;
            tx_valid  <= 1'b0;
            tx_data   <= 16'h0000;
            trig_sent <= 1'b0;
            wire_done <= 1'b0;
            wire_busy <= 1'b0;
        end else begin
            trig_prev <= trig_in;
            pend      <= (pend & ~pend_clr) | trig_edge;
            trig_sent <= 1'b0;
            wire_done <= 1'b0;

            if (wire_take) begin
                wire_buf  <= wire_data;
                wire_busy <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pend != 8'h00) begin
                        tsnap  <= pend;
                        ep_lat <= ep_addr;
                        state  <= T_HDR;
                    end else if (wire_busy) begin
                        ep_lat <= ep_addr;
                        state  <= W_HDR;
                    end
                end
                T_HDR: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= swap_bytes(HEADER);
                    end else if (accept) begin
                        tx_data <= swap_bytes({ep_lat, tsnap});
                        state   <= T_PAY;
                    end
                end
                T_PAY: begin
                    if (accept) begin
                        tx_valid  <= 1'b0;
                        tx_data   <= 16'h0000;
                        trig_sent <= 1'b1;
                        gap_cnt   <= GAP_LOAD;
                        state     <= GAP;
                    end
                end
                W_HDR: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= swap_bytes(UPDATAHEADER);
                    end else if (accept) begin
                        tx_data <= swap_bytes({ep_lat, 8'h00});
                        state   <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (accept) begin
                        tx_data <= swap_bytes(wire_buf);
                        state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (accept) begin
                        tx_valid  <= 1'b0;
                        tx_data   <= 16'h0000;
                        wire_done <= 1'b1;
                        wire_busy <= 1'b0;
                        gap_cnt   <= GAP_LOAD;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ok_trigger_out_framer.sv
// Directed bench for ok_trigger_out_framer: a per-cycle vector table followed by
// hand-written sequences for collisions, accumulation, set-wins and mid-frame reset.
module tb_ok_trigger_out_framer;

    logic        clk_in = 1'b0;
    logic        rst;
    logic [7:0]  trig_in;
    logic [7:0]  ep_addr;
    logic        wire_req;
    logic [15:0] wire_data;
    logic        tx_ready;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic [2:0]  state_dbg;
    logic        trig_sent;
    logic        wire_done;
    logic        wire_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ts_cnt = 0;
    int wd_cnt = 0;
    logic [15:0] got[$];
    int          got_cyc[$];
    logic [15:0] expw[$];

    typedef struct {
        logic [7:0]  trig;
        logic [7:0]  ep;
        logic        wreq;
        logic [15:0] wdata;
        logic        ready;
        logic        vld;
        logic [15:0] data;
        logic [2:0]  st;
        logic        ts;
        logic        wd;
        logic        wb;
    } vec_t;

    vec_t vecs[28];

    ok_trigger_out_framer dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .trig_in   (trig_in),
        .ep_addr   (ep_addr),
        .wire_req  (wire_req),
        .wire_data (wire_data),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .STATE     (state_dbg),
        .trig_sent (trig_sent),
        .wire_done (wire_done),
        .wire_busy (wire_busy)
    );

    always #5 clk_in = ~clk_in;

    function automatic vec_t mkVec(input logic [7:0] trig, input logic [7:0] ep,
                                   input logic wreq, input logic [15:0] wdata,
                                   input logic ready, input logic vld,
                                   input logic [15:0] data, input logic [2:0] st,
                                   input logic ts, input logic wd, input logic wb);
        vec_t v;
        v.trig = trig; v.ep = ep; v.wreq = wreq; v.wdata = wdata; v.ready = ready;
        v.vld = vld; v.data = data; v.st = st; v.ts = ts; v.wd = wd; v.wb = wb;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        trig_in   = v.trig;
        ep_addr   = v.ep;
        wire_req  = v.wreq;
        wire_data = v.wdata;
        tx_ready  = v.ready;
    endtask

    // One clock; sample just after the edge and log every word the bus accepts next edge.
    task automatic stepCycle();
        @(posedge clk_in);
        #1;
        cyc++;
        if (tx_valid && tx_ready) begin
            got.push_back(tx_data);
            got_cyc.push_back(cyc);
        end
        if (trig_sent) ts_cnt++;
        if (wire_done) wd_cnt++;
    endtask

    task automatic clearLog();
        got.delete();
        got_cyc.delete();
        ts_cnt = 0;
        wd_cnt = 0;
    endtask

    task automatic waitState(input logic [2:0] target, input int limit, input string tag);
        int n;
        n = 0;
        while (state_dbg !== target && n < limit) begin
            stepCycle();
            n++;
        end
        if (state_dbg !== target)
            checkOutput({tag, "_timeout"}, {29'd0, state_dbg}, {29'd0, target});
    endtask

    task automatic checkWords(input string tag);
        checkOutput({tag, "_count"}, got.size(), expw.size());
        for (int i = 0; i < expw.size(); i++) begin
            if (i < got.size())
                checkOutput($sformatf("%s_word%0d", tag, i), {16'd0, got[i]}, {16'd0, expw[i]});
            else
                checkOutput($sformatf("%s_word%0d", tag, i), 32'hFFFF_FFFF, {16'd0, expw[i]});
        end
    endtask

    initial begin
        // Single edge, backpressure on payload, then wire frame with dropped requests.
        vecs[0]  = mkVec(8'h01, 8'h40, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mkVec(8'h01, 8'h40, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mkVec(8'h01, 8'h40, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hE5C7, 3'd1, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mkVec(8'h01, 8'h40, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0140, 3'd2, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mkVec(8'h01, 8'h40, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd6, 1'b1, 1'b0, 1'b0);
        vecs[5]  = mkVec(8'h01, 8'h40, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mkVec(8'h01, 8'h40, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mkVec(8'h00, 8'h40, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mkVec(8'h01, 8'h40, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mkVec(8'h01, 8'h40, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b0);
        vecs[10] = mkVec(8'h01, 8'h40, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hE5C7, 3'd1, 1'b0, 1'b0, 1'b0);
        vecs[11] = mkVec(8'h01, 8'h40, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0140, 3'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 12; i <= 16; i++)
            vecs[i] = mkVec(8'h01, 8'h40, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0140, 3'd2, 1'b0, 1'b0, 1'b0);
        vecs[17] = mkVec(8'h01, 8'h40, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd6, 1'b1, 1'b0, 1'b0);
        vecs[18] = mkVec(8'h01, 8'h40, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        vecs[19] = mkVec(8'h01, 8'h22, 1'b1, 16'h1234, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1);
        vecs[20] = mkVec(8'h01, 8'h22, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd3, 1'b0, 1'b0, 1'b1);
        vecs[21] = mkVec(8'h01, 8'h22, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h9EB7, 3'd3, 1'b0, 1'b0, 1'b1);
        vecs[22] = mkVec(8'h01, 8'h22, 1'b1, 16'hABCD, 1'b1, 1'b1, 16'h0022, 3'd4, 1'b0, 1'b0, 1'b1);
        vecs[23] = mkVec(8'h01, 8'h22, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h3412, 3'd5, 1'b0, 1'b0, 1'b1);
        vecs[24] = mkVec(8'h01, 8'h22, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd6, 1'b0, 1'b1, 1'b0);
        vecs[25] = mkVec(8'h01, 8'h22, 1'b1, 16'hABCD, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        vecs[26] = mkVec(8'h01, 8'h22, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        vecs[27] = mkVec(8'h01, 8'h22, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);

        rst = 1'b1; trig_in = 8'h00; ep_addr = 8'h40; wire_req = 1'b0;
        wire_data = 16'h0000; tx_ready = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("rst_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("rst_data", {16'd0, tx_data}, 32'd0);
        checkOutput("rst_state", {29'd0, state_dbg}, 32'd0);
        checkOutput("rst_trig_sent", {31'd0, trig_sent}, 32'd0);
        checkOutput("rst_wire_done", {31'd0, wire_done}, 32'd0);
        checkOutput("rst_wire_busy", {31'd0, wire_busy}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 28; i++) begin
            applyStimulus(vecs[i]);
            stepCycle();
            checkOutput($sformatf("v%0d_valid", i), {31'd0, tx_valid}, {31'd0, vecs[i].vld});
            checkOutput($sformatf("v%0d_data", i), {16'd0, tx_data}, {16'd0, vecs[i].data});
            checkOutput($sformatf("v%0d_state", i), {29'd0, state_dbg}, {29'd0, vecs[i].st});
            checkOutput($sformatf("v%0d_trig_sent", i), {31'd0, trig_sent}, {31'd0, vecs[i].ts});
            checkOutput($sformatf("v%0d_wire_done", i), {31'd0, wire_done}, {31'd0, vecs[i].wd});
            checkOutput($sformatf("v%0d_wire_busy", i), {31'd0, wire_busy}, {31'd0, vecs[i].wb});
        end

        // Collision: trigger edge and wire request together; trigger frame wins.
        wire_req = 1'b0; ep_addr = 8'h40; tx_ready = 1'b1; trig_in = 8'h00;
        stepCycle();
        stepCycle();
        clearLog();
        trig_in = 8'h02; wire_req = 1'b1; wire_data = 16'h5678;
        stepCycle();
        for (int k = 0; k < 40; k++) begin
            wire_req  = (k == 4);
            wire_data = (k == 4) ? 16'h9999 : 16'h0000;
            stepCycle();
        end
        expw = '{16'hE5C7, 16'h0240, 16'h9EB7, 16'h0040, 16'h7856};
        checkWords("coll");
        checkOutput("coll_trig_sent_cnt", ts_cnt, 32'd1);
        checkOutput("coll_wire_done_cnt", wd_cnt, 32'd1);
        if (got_cyc.size() >= 3)
            checkOutput("coll_gap", {31'd0, (got_cyc[2] - got_cyc[1]) >= 2}, 32'd1);
        checkOutput("coll_busy_end", {31'd0, wire_busy}, 32'd0);

        // Edges arriving mid-frame accumulate into the next frame.
        trig_in = 8'h00;
        stepCycle();
        stepCycle();
        clearLog();
        trig_in = 8'h01;
        waitState(3'd1, 20, "acc_launch");
        trig_in = 8'h00;
        stepCycle();
        trig_in = 8'h09;
        for (int k = 0; k < 30; k++) stepCycle();
        expw = '{16'hE5C7, 16'h0140, 16'hE5C7, 16'h0940};
        checkWords("acc");
        checkOutput("acc_trig_sent_cnt", ts_cnt, 32'd2);
        if (got_cyc.size() >= 3)
            checkOutput("acc_gap", {31'd0, (got_cyc[2] - got_cyc[1]) >= 2}, 32'd1);

        // New edge in the same cycle the snapshot clears that bit: it stays pending.
        trig_in = 8'h00;
        stepCycle();
        stepCycle();
        clearLog();
        trig_in = 8'h01;
        waitState(3'd1, 20, "sw_launch");
        trig_in = 8'h05;
        waitState(3'd6, 20, "sw_gap1");
        waitState(3'd1, 20, "sw_launch2");
        waitState(3'd6, 20, "sw_gap2");
        trig_in = 8'h01;
        stepCycle();
        trig_in = 8'h05;
        for (int k = 0; k < 30; k++) stepCycle();
        expw = '{16'hE5C7, 16'h0140, 16'hE5C7, 16'h0440, 16'hE5C7, 16'h0440};
        checkWords("setwin");

        // Reset during W_ADDR aborts the wire frame without a done pulse.
        trig_in = 8'h00;
        stepCycle();
        stepCycle();
        clearLog();
        wire_req = 1'b1; wire_data = 16'hBEEF;
        stepCycle();
        wire_req = 1'b0;
        waitState(3'd4, 20, "rst_waddr");
        rst = 1'b1;
        stepCycle();
        checkOutput("midrst_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("midrst_state", {29'd0, state_dbg}, 32'd0);
        checkOutput("midrst_busy", {31'd0, wire_busy}, 32'd0);
        checkOutput("midrst_data", {16'd0, tx_data}, 32'd0);
        rst = 1'b0;
        clearLog();
        for (int k = 0; k < 10; k++) stepCycle();
        checkOutput("midrst_no_done", wd_cnt, 32'd0);
        checkOutput("midrst_no_words", got.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ok_trigger_out_framer.md
Name: ok_trigger_out_framer

Overview:
- Transmit-side counterpart of the host-to-FPGA trigger receiver.
- Turns local trigger events and wire-out requests into framed 16-bit words on the shared byte-swapped OK word bus.
- Trigger frame layout: HEADER, then {ep_addr, payload}.
- Sits between the decoding core (event/wire sources) and the OK pipe/word transmitter.

Parameters:
- HEADER, 16'hC7E5, header word of a trigger frame.
- UPDATAHEADER, 16'hB79E, header word of a wire-out frame.
- GAP_CYCLES, 1, idle cycles forced after every frame so the far-end FINISH state is never fed data (range 1..15).

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- trig_in  input  8  level trigger sources; a rising edge on any bit raises that bit's pending flag.
- ep_addr  input  8  endpoint address placed in the upper byte of the address word; sampled at frame launch.
- wire_req  input  1  one-cycle request to send wire_data.
- wire_data  input  16  wire-out value; captured in the cycle wire_req=1 is accepted.
- tx_ready  input  1  downstream accepts tx_data when tx_valid&tx_ready.
- tx_valid  output  1  tx_data valid.
- tx_data  output  16  outgoing word, byte-swapped: {word[7:0], word[15:8]}.
- STATE  output  3  current FSM state (debug).
- trig_sent  output  1  one-cycle pulse when a trigger payload word is accepted.
- wire_done  output  1  one-cycle pulse when the wire data word is accepted.
- wire_busy  output  1  high while a wire request is held or in flight; wire_req is ignored while high.

Behaviour:
- Reset: tx_valid=0, tx_data=0, STATE=IDLE(0), trig_sent=0, wire_done=0, wire_busy=0. Pending flags, trig_in history register, wire buffer and gap counter are all cleared.
- Edge detect: trig_in is registered once. pend[i] is set when trig_in[i]=1 and prev[i]=0. The history register clears on reset, so a bit held high through reset produces an edge on the first cycle after reset.
- Wire capture: when wire_req=1 and wire_busy=0, latch wire_data and set wire_busy in the next cycle. wire_busy clears in the cycle wire_done pulses.
- FSM states and encodings:
  - IDLE 0: if pend≠0, snapshot pend into tsnap, clear the snapshotted bits, go to T_HDR. Otherwise, if the wire buffer is held, go to W_HDR. Triggers have priority.
  - T_HDR 1: present HEADER. On accept, go to T_PAY.
  - T_PAY 2: present {ep_addr, tsnap}. On accept, pulse trig_sent and go to GAP.
  - W_HDR 3: present UPDATAHEADER. On accept, go to W_ADDR.
  - W_ADDR 4: present {ep_addr, 8'h00}. On accept, go to W_DATA.
  - W_DATA 5: present the latched wire data. On accept, pulse wire_done and go to GAP.
  - GAP 6: tx_valid=0 for GAP_CYCLES cycles, then go to IDLE.
- tx_valid and tx_data are registered and become valid the cycle after the state is entered.
- Handshake rules:
  - While tx_valid=1 and tx_ready=0, tx_data holds stable and tx_valid stays high.
  - tx_valid never deasserts mid-frame except through reset.
  - Minimum trigger frame latency: edge on trig_in, then tx_valid with HEADER 3 cycles later when tx_ready=1 (1 cycle registration, 1 cycle IDLE decision, 1 cycle output register).
- ep_addr is sampled once at IDLE exit and held for the whole frame.
- Boundary conditions:
  - A new edge on a bit in the same cycle that bit is cleared by the snapshot: set wins, and the bit stays pending for the next frame.
  - Edges arriving mid-frame accumulate in pend and are never lost. Multiple edges on one bit before launch merge into one pending flag.
  - wire_req while wire_busy=1 is dropped. wire_req in the same cycle the buffer frees (wire_done) is also dropped.
  - Simultaneous pend≠0 and wire pending in IDLE: the trigger frame goes first, then GAP, then the wire frame.
  - Reset asserted mid-frame: abort immediately. Outputs return to reset values the next cycle and no partial frame completes.
- Payload width: only the low 8 bits of the address word carry triggers. Receivers use whatever subset they need (currently bits [1:0]).

Test Plan:
- Reset then single edge: trig_in[0] 0→1, tx_ready=1 → tx_data 16'hE5C7 then 16'h01xx (with ep_addr=8'h40, second word = 16'h0140). trig_sent pulses once, then 1 idle cycle.
- Backpressure: tx_ready=0 for 5 cycles during T_PAY → tx_data holds 16'h0140 and tx_valid stays high. trig_sent fires exactly once, on the accept cycle.
- Wire frame: wire_req with wire_data=16'h1234, ep_addr=8'h22 → words 16'h9EB7, 16'h0022, 16'h3412. wire_done pulses and wire_busy falls the same cycle.
- Collision: trig_in[1] edge and wire_req in the same cycle → trigger frame with payload 8'h02 first, ≥1 gap cycle, then the wire frame. A second wire_req during the sequence is ignored.
- Mid-frame edge accumulation: trig_in[0] edge launches a frame; trig_in[0] and trig_in[3] edges during T_HDR → second frame payload 8'h09. No edge is lost.
- Reset mid-frame: assert rst during W_ADDR → next cycle tx_valid=0, STATE=0, wire_busy=0. No wire_done pulse occurs.
